// File: rtl/rotate_writer.sv
// rotate_writer: stores a raster camera stream into the frame buffer rotated 90 deg clockwise.
// Optional macro ROTATE_WR_MIRROR_EN: row offset counts up instead (transpose / mirrored rotation).
`default_nettype none

module rotate_writer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 320
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    input  logic        pixel_valid_in,
    input  logic [15:0] pixel_in,
    output logic [16:0] wr_addr_out,
    output logic [15:0] wr_data_out,
    output logic        wr_en_out,
    output logic        frame_done_out,
    output logic        frame_err_out,
    output logic        busy_out
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
    localparam logic [16:0]   BASE_STEP = 17'(HEIGHT);
`ifdef ROTATE_WR_MIRROR_EN
    localparam logic [16:0]   OFF_INIT  = 17'd0;
`else
    localparam logic [16:0]   OFF_INIT  = 17'(HEIGHT - 1);
`endif

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x, x_eff, x_nxt;
    logic [YW-1:0] y, y_eff, y_nxt;
    logic [16:0]   base, base_eff, base_nxt;
    logic [16:0]   off, off_eff, off_nxt;
    logic          active, last_px, restart, abort, accept;

    // The *_eff values are the position of the pixel presented this cycle,
    // which is (0,0) whenever a frame start takes effect.
    always_comb begin
        active    = (state == ACTIVE);
        last_px   = active && pixel_valid_in && (x == X_LAST) && (y == Y_LAST);
        restart   = frame_start_in && !last_px;
        abort     = restart && active;
        accept    = pixel_valid_in && (active || frame_start_in);

        x_eff     = restart ? '0       : x;
        y_eff     = restart ? '0       : y;
        base_eff  = restart ? 17'd0    : base;
        off_eff   = restart ? OFF_INIT : off;

        state_nxt = state;
        x_nxt     = x_eff;
        y_nxt     = y_eff;
        base_nxt  = base_eff;
        off_nxt   = off_eff;

        if (frame_start_in) begin
            state_nxt = ACTIVE;
        end else if (last_px) begin
            state_nxt = IDLE;
        end

        if (last_px) begin
            x_nxt    = '0;
            y_nxt    = '0;
            base_nxt = 17'd0;
            off_nxt  = OFF_INIT;
        end else if (accept) begin
            if (x_eff == X_LAST) begin
                x_nxt    = '0;
                y_nxt    = y_eff + YW'(1);
                base_nxt = 17'd0;
`ifdef ROTATE_WR_MIRROR_EN
                off_nxt  = off_eff + 17'd1;
`else
                off_nxt  = off_eff - 17'd1;
`endif
            end else begin
                x_nxt    = x_eff + XW'(1);
                base_nxt = base_eff + BASE_STEP;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
            base  <= 17'd0;
            off   <= OFF_INIT;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
            y     <= y_nxt;
            base  <= base_nxt;
            off   <= off_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_addr_out    <= 17'd0;
            wr_data_out    <= 16'd0;
            wr_en_out      <= 1'b0;
            frame_done_out <= 1'b0;
            frame_err_out  <= 1'b0;
        end else begin
            wr_en_out      <= accept;
            frame_done_out <= last_px;
            frame_err_out  <= abort;
            if (accept) begin
                wr_addr_out <= base_eff + off_eff;
                wr_data_out <= pixel_in;
            end
        end
    end

    assign busy_out = active;

endmodule

`default_nettype wire

// File: tb/tb_rotate_writer.sv
// tb_rotate_writer: randomized scoreboard bench for rotate_writer (WIDTH=4, HEIGHT=3).
`default_nettype none

module tb_rotate_writer;

    localparam int W = 4;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pixel_valid = 1'b0;
    logic [15:0] pixel = 16'd0;
    logic [16:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_en, frame_done, frame_err, busy;

    rotate_writer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .frame_start_in (frame_start),
        .pixel_valid_in (pixel_valid),
        .pixel_in       (pixel),
        .wr_addr_out    (wr_addr),
        .wr_data_out    (wr_data),
        .wr_en_out      (wr_en),
        .frame_done_out (frame_done),
        .frame_err_out  (frame_err),
        .busy_out       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [16:0] addr;
        logic [15:0] data;
        logic        done;
        logic        err;
    } ev_t;

    ev_t expq[$];
    int  wr_log[$];
    int  compared   = 0;
    int  mismatched = 0;

`ifdef ROTATE_WR_MIRROR_EN
    int exp_addr[12] = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
`else
    int exp_addr[12] = '{2, 5, 8, 11, 1, 4, 7, 10, 0, 3, 6, 9};
`endif

    // Reference model: frame position as a linear pixel index.
    bit m_active = 1'b0;
    int m_n      = 0;

    function automatic logic [16:0] addr_of(input int n);
        int px, py;
        px = n % W;
        py = n / W;
`ifdef ROTATE_WR_MIRROR_EN
        return 17'(H * px + py);
`else
        return 17'(H * px + (H - 1 - py));
`endif
    endfunction

    task automatic model_step(input bit fs, input bit v, input logic [15:0] d);
        ev_t e;
        bit  last;
        e      = '0;
        e.data = d;
        last   = m_active && v && (m_n == W * H - 1);
        if (last) begin
            e.en   = 1'b1;
            e.addr = addr_of(m_n);
            e.done = 1'b1;
            expq.push_back(e);
            m_n      = 0;
            m_active = fs;
        end else if (fs) begin
            e.err = m_active;
            if (v) begin
                e.en   = 1'b1;
                e.addr = addr_of(0);
                m_n    = 1;
            end else begin
                m_n = 0;
            end
            if (e.en || e.err) expq.push_back(e);
            m_active = 1'b1;
        end else if (m_active && v) begin
            e.en   = 1'b1;
            e.addr = addr_of(m_n);
            expq.push_back(e);
            m_n++;
        end
    endtask

    task automatic cycle(input bit fs, input bit v);
        logic [15:0] d;
        @(negedge clk);
        d           = 16'($urandom);
        frame_start = fs;
        pixel_valid = v;
        pixel       = d;
        model_step(fs, v, d);
        @(posedge clk);
        #2;
        compared++;
        if (busy !== m_active) begin
            mismatched++;
            $display("FAIL busy: got %b expected %b at %0t", busy, m_active, $time);
        end
    endtask

    task automatic check_log(input string name);
        compared++;
        if (wr_log.size() != 12) begin
            mismatched++;
            $display("FAIL %s_count: got %0d writes expected 12", name, wr_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                compared++;
                if (wr_log[i] != exp_addr[i]) begin
                    mismatched++;
                    $display("FAIL %s_addr[%0d]: got %0d expected %0d", name, i, wr_log[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic check_zero(input string name);
        compared++;
        if (wr_addr !== 17'd0 || wr_data !== 16'd0 || wr_en !== 1'b0 ||
            frame_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s: got addr=%0d data=%h en=%b done=%b err=%b busy=%b expected all zero",
                     name, wr_addr, wr_data, wr_en, frame_done, frame_err, busy);
        end
    endtask

    // Monitor: latency is fixed, so every due expectation must appear this cycle.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (wr_en || frame_done || frame_err) begin
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_out: got en=%b addr=%0d done=%b err=%b expected none at %0t",
                             wr_en, wr_addr, frame_done, frame_err, $time);
                end else begin
                    ev_t e;
                    e = expq.pop_front();
                    if (wr_en !== e.en || frame_done !== e.done || frame_err !== e.err ||
                        (e.en && (wr_addr !== e.addr || wr_data !== e.data))) begin
                        mismatched++;
                        $display("FAIL write_event: got en=%b addr=%0d data=%h done=%b err=%b expected en=%b addr=%0d data=%h done=%b err=%b at %0t",
                                 wr_en, wr_addr, wr_data, frame_done, frame_err,
                                 e.en, e.addr, e.data, e.done, e.err, $time);
                    end
                end
                if (wr_en) wr_log.push_back(int'(wr_addr));
            end else if (expq.size() != 0) begin
                ev_t e;
                e = expq.pop_front();
                compared++;
                mismatched++;
                $display("FAIL missing_out: got nothing expected en=%b addr=%0d done=%b err=%b at %0t",
                         e.en, e.addr, e.done, e.err, $time);
            end
        end
    end

    initial begin
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Valid pixels while idle must not write
        repeat (5) cycle(1'b0, 1'b1);

        // Full frame, continuous valid
        wr_log.delete();
        cycle(1'b1, 1'b1);
        repeat (W * H - 1) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);
        check_log("frame_cont");

        // Same frame with random valid gaps
        wr_log.delete();
        cycle(1'b1, 1'($urandom_range(0, 1)));
        guard = 0;
        while (m_active && guard < 200) begin
            cycle(1'b0, $urandom_range(0, 2) != 0);
            guard++;
        end
        compared++;
        if (m_active) begin
            mismatched++;
            $display("FAIL gap_frame_timeout: got %0d cycles expected frame to finish", guard);
        end
        repeat (2) cycle(1'b0, 1'b0);
        check_log("frame_gaps");

        // Early frame_start after 5 pixels
        cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (W * H - 1) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);

        // Early frame_start without a pixel
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (W * H) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);

        // frame_start coincident with last pixel
        cycle(1'b1, 1'b1);
        repeat (W * H - 2) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        wr_log.delete();
        repeat (W * H) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);
        check_log("frame_after_coincident");

        // Random stress
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0);
        end

        // Reset mid-frame
        cycle(1'b1, 1'b1);
        repeat (5) cycle(1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        expq.delete();
        m_active = 1'b0;
        m_n      = 0;
        @(negedge clk);
        frame_start = 1'b0;
        pixel_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cycle(1'b0, 1'b1);
        wr_log.delete();
        cycle(1'b1, 1'b1);
        repeat (W * H - 1) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);
        check_log("frame_after_reset");

        compared++;
        if (expq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expectations expected 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
